// File: rtl/robs_pkg.sv
// Shared types and control-word bit map for the Robertson multiplier controller.
// Pure definitions: no logic, no latency, no flow control.
package robs_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    INIT     = 4'd2,
    TEST     = 4'd3,
    ADD      = 4'd4,
    ADD_WB   = 4'd5,
    SHIFT_LD = 4'd6,
    SHIFT    = 4'd7,
    SHIFT_WB = 4'd8,
    WB       = 4'd9,
    DONE     = 4'd10
  } state_t;

  localparam int CW = 15;

  localparam int C_LD_Y      = 0;
  localparam int C_LD_CNT    = 1;
  localparam int C_CLR_A     = 2;
  localparam int C_LD_X      = 3;
  localparam int C_RH_SEL_LO = 4;
  localparam int C_RH_SEL_HI = 5;
  localparam int C_RL_SEL    = 6;
  localparam int C_X_SRC     = 7;
  localparam int C_LD_RH     = 8;
  localparam int C_LD_RL     = 9;
  localparam int C_ALU_ADD   = 10;
  localparam int C_SR_SHR    = 11;
  localparam int C_LD_SR     = 12;
  localparam int C_CNT_DEC   = 13;
  localparam int C_LD_A      = 14;

  localparam logic [1:0] RH_A   = 2'b00;
  localparam logic [1:0] RH_SR  = 2'b01;
  localparam logic [1:0] RH_ALU = 2'b10;

endpackage

// File: rtl/robs_ctrl_decode.sv
// Moore decode of (state, sub) into datapath control word, busy and done.
// Combinational, zero latency; no flow control.
module robs_ctrl_decode
  import robs_pkg::*;
(
  input  state_t          i_state,
  input  logic            i_sub,
  output logic [CW-1:0]   o_c,
  output logic            o_busy,
  output logic            o_done
);

  always_comb begin
    o_c    = '0;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (i_state)
      IDLE: o_busy = 1'b0;
      LOAD: begin
        o_c[C_LD_Y]   = 1'b1;
        o_c[C_LD_CNT] = 1'b1;
        o_c[C_CLR_A]  = 1'b1;
        o_c[C_LD_X]   = 1'b1;
      end
      INIT: begin
        o_c[C_RH_SEL_HI:C_RH_SEL_LO] = RH_A;
        o_c[C_LD_RH]   = 1'b1;
        o_c[C_LD_RL]   = 1'b1;
        o_c[C_CNT_DEC] = 1'b1;
      end
      TEST: o_c = '0;
      // The sign-bit iteration subtracts; ADD gives the ALU its pipeline cycle.
      ADD: o_c[C_ALU_ADD] = ~i_sub;
      ADD_WB: begin
        o_c[C_ALU_ADD] = ~i_sub;
        o_c[C_RH_SEL_HI:C_RH_SEL_LO] = RH_ALU;
        o_c[C_LD_RH]   = 1'b1;
      end
      SHIFT_LD: o_c[C_LD_SR]  = 1'b1;
      SHIFT:    o_c[C_SR_SHR] = 1'b1;
      SHIFT_WB: begin
        o_c[C_RH_SEL_HI:C_RH_SEL_LO] = RH_SR;
        o_c[C_RL_SEL]  = 1'b1;
        o_c[C_LD_RH]   = 1'b1;
        o_c[C_LD_RL]   = 1'b1;
        o_c[C_CNT_DEC] = 1'b1;
      end
      WB: begin
        o_c[C_LD_A]  = 1'b1;
        o_c[C_LD_X]  = 1'b1;
        o_c[C_X_SRC] = 1'b1;
      end
      DONE: o_done = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/robs_controller.sv
// Sequencing FSM for the signed Robertson multiplier: done 36..52 cycles after start.
// No backpressure: start is sampled only in IDLE and ignored while busy.
module robs_controller
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          zr,
  input  logic          zq,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          done
);

  // The datapath's zq only detects q%8==0, so no other width can terminate correctly.
  if (WIDTH != 8) begin : g_width_check
    $error("robs_controller supports WIDTH=8 only");
  end

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_sub;
  logic [CW-1:0] w_c;
  logic          w_busy;
  logic          w_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == TEST) begin
        r_last <= zq;
        r_sub  <= zq;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? LOAD : IDLE;
      LOAD:     w_next = INIT;
      INIT:     w_next = TEST;
      TEST:     w_next = zr ? SHIFT_LD : ADD;
      ADD:      w_next = ADD_WB;
      ADD_WB:   w_next = SHIFT_LD;
      SHIFT_LD: w_next = SHIFT;
      SHIFT:    w_next = SHIFT_WB;
      // q has already wrapped past zero here, so the flag from TEST decides.
      SHIFT_WB: w_next = r_last ? WB : TEST;
      WB:       w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  robs_ctrl_decode u_decode (
    .i_state (r_state),
    .i_sub   (r_sub),
    .o_c     (w_c),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  assign c    = w_c;
  assign busy = w_busy;
  assign done = w_done;

endmodule

// File: tb/tb_robs_controller.sv
// Controller bench with a behavioural Robertson datapath and a product/latency scoreboard.
module tb_robs_controller;
  import robs_pkg::*;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          zr;
  logic          zq;
  logic [CW-1:0] c;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  robs_controller #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .zr    (zr),
    .zq    (zq),
    .c     (c),
    .busy  (busy),
    .done  (done)
  );

  // Behavioural datapath driven by the control word.
  logic [7:0]  op_mcand  = 8'h00;
  logic [7:0]  op_mplier = 8'h00;
  logic [7:0]  dp_a = 8'h00, dp_x = 8'h00, dp_y = 8'h00, dp_q = 8'h00;
  logic [7:0]  dp_rh = 8'h00, dp_rl = 8'h00, dp_alu = 8'h00;
  logic [15:0] dp_sr = 16'h0000;

  always @(posedge clk) begin
    dp_alu <= c[C_ALU_ADD] ? dp_rh + dp_y : dp_rh - dp_y;
    if (c[C_LD_Y]) dp_y <= op_mcand;
    if (c[C_LD_CNT]) dp_q <= 8'd8;
    else if (c[C_CNT_DEC]) dp_q <= dp_q - 8'd1;
    if (c[C_CLR_A]) dp_a <= 8'h00;
    else if (c[C_LD_A]) dp_a <= dp_rh;
    if (c[C_LD_X]) dp_x <= c[C_X_SRC] ? dp_rl : op_mplier;
    if (c[C_LD_RH]) begin
      case (c[C_RH_SEL_HI:C_RH_SEL_LO])
        RH_A:    dp_rh <= dp_a;
        RH_SR:   dp_rh <= dp_sr[15:8];
        RH_ALU:  dp_rh <= dp_alu;
        default: dp_rh <= 8'hxx;
      endcase
    end
    if (c[C_LD_RL]) dp_rl <= c[C_RL_SEL] ? dp_sr[7:0] : dp_x;
    if (c[C_LD_SR]) dp_sr <= {dp_rh, dp_rl};
    else if (c[C_SR_SHR]) dp_sr <= {dp_sr[15], dp_sr[15:1]};
  end

  assign zr = ~dp_rl[0];
  assign zq = (dp_q[2:0] == 3'd0);

  // Free-running event counters, sampled mid-cycle.
  int n_c13 = 0, n_ld = 0, n_add = 0, n_sub = 0;
  always @(negedge clk) begin
    if (c[C_CNT_DEC]) n_c13 <= n_c13 + 1;
    if (c[C_LD_Y]) n_ld <= n_ld + 1;
    if (c[C_LD_RH] && c[C_RH_SEL_HI:C_RH_SEL_LO] == RH_ALU) begin
      if (c[C_ALU_ADD]) n_add <= n_add + 1;
      else n_sub <= n_sub + 1;
    end
  end

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          nadd;
    int          nsub;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] mc, input logic [7:0] mp);
    exp_t e;
    logic signed [15:0] a;
    logic signed [15:0] b;
    a = $signed(mc);
    b = $signed(mp);
    e.prod = a * b;
    e.lat  = 36 + 2 * $countones(mp);
    e.nsub = int'(mp[7]);
    e.nadd = $countones(mp) - int'(mp[7]);
    op_mcand  = mc;
    op_mplier = mp;
    sb.push_back(e);
  endtask

  // Called during the IDLE cycle in which start is sampled (cycle 0).
  task automatic measure(input bit hold, input bit poke);
    exp_t e;
    int   cyc;
    bit   seen;
    int   b13, bld, badd, bsub;
    b13 = n_c13; bld = n_ld; badd = n_add; bsub = n_sub;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check_eq("load_c0", int'(c[C_LD_Y]), 1);
        check_eq("load_busy", int'(busy), 1);
        if (!hold) start = 1'b0;
      end
      if (poke && cyc == 10) start = 1'b1;
      if (poke && cyc == 12) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        check_eq("done_timeout", 0, 1);
      end else begin
        check_eq("latency", cyc, e.lat);
        check_eq("product", int'({dp_a, dp_x}), int'(e.prod));
        check_eq("busy_at_done", int'(busy), 1);
        check_eq("c13_count", n_c13 - b13, 9);
        check_eq("load_count", n_ld - bld, 1);
        check_eq("add_wb_count", n_add - badd, e.nadd);
        check_eq("sub_wb_count", n_sub - bsub, e.nsub);
        @(posedge clk); #1;
        check_eq("done_pulse", int'(done), 0);
        check_eq("idle_busy", int'(busy), 0);
        check_eq("product_hold", int'({dp_a, dp_x}), int'(e.prod));
      end
    end
  endtask

  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input bit poke);
    @(negedge clk);
    issue(mc, mp);
    start = 1'b1;
    measure(1'b0, poke);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  nwb;
    int  guard;
    bit  hit;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_c", int'(c), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;

    run_op(8'd5, 8'd3, 1'b0);
    run_op(8'd5, 8'hFD, 1'b1);
    run_op(8'h7F, 8'h00, 1'b0);

    // start held high across two operations
    @(negedge clk);
    issue(8'd9, 8'd6);
    start = 1'b1;
    measure(1'b1, 1'b0);
    issue(8'hF6, 8'h81);
    measure(1'b0, 1'b0);

    // Reset in ADD_WB of iteration 3
    @(negedge clk);
    op_mcand  = 8'd5;
    op_mplier = 8'h0B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nwb = 0; guard = 0; hit = 1'b0;
    while (!hit && guard < 100) begin
      if (c[C_CNT_DEC] && c[C_RL_SEL]) nwb++;
      else if (nwb == 3 && c[C_LD_RH] && c[C_RH_SEL_HI:C_RH_SEL_LO] == RH_ALU) hit = 1'b1;
      if (!hit) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    check_eq("abort_point_reached", int'(hit), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_c", int'(c), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(8'hFD, 8'hFB, 1'b0);

    // Reset wins over simultaneous start
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_start_busy", int'(busy), 0);
    check_eq("rst_start_c", int'(c), 0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_start_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/robs_controller.md
Name: robs_controller

Overview:
- Sequencing FSM for the signed Robertson's multiplier datapath (robs_datapath, WIDTH=8).
- Accepts a start request and drives the 15-bit datapath control word c[14:0] through load, add/subtract, arithmetic-shift and writeback steps, using the datapath status bits zr and zq.
- Reports busy/done to the requester; the product is read from the datapath product bus after done.

Parameters:
WIDTH, 8, operand width; only 8 is supported, because zq detects q%8==0.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
zr  input  1  datapath: R LSB is 0 (current multiplier bit = 0)
zq  input  1  datapath: iteration counter q%8==0
c  output  15  datapath control word (bit map below)
busy  output  1  high from LOAD through DONE
done  output  1  one-cycle pulse in DONE

Behaviour:
- Control word bit map:
  - c0 load Y; c1 load counter with WIDTH; c2 clear A; c3 load X.
  - c5:4 R-high select: 00 A, 01 SR-high, 10 ALU. c6 R-low select: 0 X, 1 SR-low.
  - c7 X source: 0 multiplier, 1 R-low. c8 load R-high; c9 load R-low.
  - c10 ALU op: 1 add, 0 subtract. c11 SR arithmetic shift right; c12 load SR from R.
  - c13 counter decrement; c14 load A from R-high.
- Outputs are Moore: c, busy and done are decoded from the state register plus the registered flags last and sub. Any bit not listed for a state is 0.
- Reset (reset==0 at an edge, including mid-operation):
  - Next cycle: state=IDLE, c=0, busy=0, done=0, last=0, sub=0.
  - Reset wins over a simultaneous start.
- States and transitions:
  - IDLE: c=0. If start=1 -> LOAD, otherwise stay.
  - LOAD: c0,c1,c2,c3 (c7=0). -> INIT. The requester holds multiplier and multiplicand stable through this cycle.
  - INIT: c5:4=00, c6=0, c8,c9 (R<={A,X}); c13 (q: 8->7). -> TEST.
  - TEST: c=0.
    - Register last<=zq and sub<=zq.
    - zr=1 -> SHIFT_LD; zr=0 -> ADD.
  - ADD: c10=~sub (subtract on the sign-bit iteration). -> ADD_WB. This gives the addsub unit its one-cycle pipeline latency.
  - ADD_WB: c10=~sub, c5:4=10, c8. -> SHIFT_LD.
  - SHIFT_LD: c12. -> SHIFT.
  - SHIFT: c11. -> SHIFT_WB.
  - SHIFT_WB: c5:4=01, c6=1, c8, c9, c13. If last=1 -> WB, else -> TEST.
  - WB: c14 (A<=R-high); c3 with c7=1 (X<=R-low). -> DONE.
  - DONE: done=1, c=0. -> IDLE.
- Iteration rule:
  - WIDTH iterations; in iteration i, q=7-i.
  - Last iteration is detected by zq=1 in TEST.
  - After the final decrement q wraps to 255, which is ignored because last is used.
- Latency: with start sampled in IDLE at cycle 0, done is high at cycle 4 + 4*WIDTH + 2*popcount(multiplier), i.e. cycle 36 to 52. busy covers cycles 1 through done.
- Boundaries:
  - start held high: a new operation begins on the cycle after DONE.
  - start while busy: ignored, no queuing.
  - Product on {A,X} stays stable from done until the next LOAD (c2/c3).
  - Datapath A overflow, e.g. -128*-128, is out of scope for this block.

Decomposition:
- Shared package robs_pkg:
  - state_t enum: IDLE, LOAD, INIT, TEST, ADD, ADD_WB, SHIFT_LD, SHIFT, SHIFT_WB, WB, DONE.
  - Control-bit index constants: C_LD_Y=0 … C_LD_A=14.
  - Mux-select encodings: RH_A, RH_SR, RH_ALU.
- One sub-module, robs_ctrl_decode: purely combinational map from (state, sub) to c/busy/done.

Test Plan:
- Controller with robs_datapath, multiplicand=5, multiplier=3, start pulse -> done at cycle 40, product=16'h000F, exactly one c10=0 iteration absent (multiplier sign=0).
- multiplicand=5, multiplier=-3 (8'hFD) -> done at cycle 50, product=16'hFFF1. In the 8th iteration's ADD state, c10=0 (subtract).
- multiplier=0, multiplicand=8'h7F -> no ADD states visited, done at cycle 36, product=0. c13 is asserted exactly 9 times (INIT plus 8 SHIFT_WB).
- reset=0 asserted in ADD_WB of iteration 3 -> next cycle c=0, busy=0, done=0, state IDLE. A following start with -3*-5 -> product=16'h000F.
- start held high continuously for two operations -> second LOAD occurs the cycle after the first DONE. start pulses during busy cause no extra LOAD.
- reset=0 and start=1 in the same cycle -> stays IDLE, busy=0 next cycle.
